// File: rtl/packer_vr.sv
// Width-converting valid-ready packer: gathers IN_W-bit beats into OUT_W-bit words, LSB beat first.
// Define PACKER_BEATS_EN to add the data_out_beats port (count of valid beats in data_out).
module packer_vr #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 32,
  localparam int unsigned RATIO = OUT_W / IN_W,
  localparam int unsigned CNT_W = $clog2(RATIO) + 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             sync_rst,
  input  logic [IN_W-1:0]  data_in,
  input  logic             data_in_last,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             data_out_last,
`ifdef PACKER_BEATS_EN
  output logic [CNT_W-1:0] data_out_beats,
`endif
  output logic             data_out_valid,
  input  logic             data_out_ready
);

  if ((RATIO < 2) || ((OUT_W % IN_W) != 0)) begin : g_bad_cfg
    $error("packer_vr: OUT_W must be an integer multiple (>=2) of IN_W");
  end

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_full_q, out_full_d;
  logic [OUT_W-1:0] data_out_q, data_out_d;
  logic             data_out_last_q, data_out_last_d;
`ifdef PACKER_BEATS_EN
  logic [CNT_W-1:0] data_out_beats_q, data_out_beats_d;
`endif

  logic             in_shake;
  logic             out_shake;
  logic             complete;
  logic [OUT_W-1:0] merged;
  logic [OUT_W-1:0] word;

  assign data_out_valid = en & out_full_q;
  assign data_in_ready  = en & nrst & ~sync_rst & (~out_full_q | data_out_ready);
  assign in_shake       = data_in_valid & data_in_ready;
  assign out_shake      = data_out_valid & data_out_ready;
  assign complete       = in_shake & ((cnt_q == CNT_W'(RATIO - 1)) | data_in_last);

  assign data_out      = data_out_q;
  assign data_out_last = data_out_last_q;
`ifdef PACKER_BEATS_EN
  assign data_out_beats = data_out_beats_q;
`endif

  // Merge the incoming beat into lane cnt; lanes above cnt are zero-padded in the closed word.
  always_comb begin
    merged = acc_q;
    word   = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (cnt_q == CNT_W'(i)) merged[i*IN_W +: IN_W] = data_in;
      if (CNT_W'(i) <= cnt_q) word[i*IN_W +: IN_W] = merged[i*IN_W +: IN_W];
    end
  end

  always_comb begin
    acc_d           = acc_q;
    cnt_d           = cnt_q;
    out_full_d      = out_full_q;
    data_out_d      = data_out_q;
    data_out_last_d = data_out_last_q;
`ifdef PACKER_BEATS_EN
    data_out_beats_d = data_out_beats_q;
`endif

    if (complete) begin
      data_out_d      = word;
      data_out_last_d = data_in_last;
      out_full_d      = 1'b1;
      cnt_d           = '0;
      acc_d           = '0;
`ifdef PACKER_BEATS_EN
      data_out_beats_d = cnt_q + CNT_W'(1);
`endif
    end else if (in_shake) begin
      acc_d = merged;
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A new word arriving in the same cycle as the drain keeps the register full.
    if (out_shake && !complete) out_full_d = 1'b0;

    if (sync_rst) begin
      acc_d           = '0;
      cnt_d           = '0;
      out_full_d      = 1'b0;
      data_out_d      = '0;
      data_out_last_d = 1'b0;
`ifdef PACKER_BEATS_EN
      data_out_beats_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q           <= '0;
      cnt_q           <= '0;
      out_full_q      <= 1'b0;
      data_out_q      <= '0;
      data_out_last_q <= 1'b0;
`ifdef PACKER_BEATS_EN
      data_out_beats_q <= '0;
`endif
    end else begin
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      out_full_q      <= out_full_d;
      data_out_q      <= data_out_d;
      data_out_last_q <= data_out_last_d;
`ifdef PACKER_BEATS_EN
      data_out_beats_q <= data_out_beats_d;
`endif
    end
  end

endmodule
